can_msg_ram: RTL and testbench

Parametrised dual-port message RAM for the CAN controller. It replaces the single-port 256×8 intelligent memory. A host port and a CAN-engine port share one storage array. The block clears the array automatically after reset and on request, and it arbitrates same-address write collisions. It sits between the host bus interface and the CAN protocol engine, holding TX/RX message bytes.

---
 rtl/can_mem_pkg.sv | 12 +
 rtl/can_mem_clear_ctrl.sv | 33 +++
 rtl/can_msg_ram.sv | 59 +++++
 tb/tb_can_msg_ram.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/can_mem_pkg.sv
// can_mem_pkg: shared types, defaults and width helper for the CAN message RAM
package can_mem_pkg;
  typedef enum logic {ST_CLEAR, ST_IDLE} mem_state_e;
  localparam int CAN_MEM_DATA_W = 8;
  localparam int CAN_MEM_DEPTH = 256;
  function automatic int can_mem_clog2(input int n);
    int r;
    r = 0;
    for (int v = n - 1; v > 0; v = v >> 1) r++;
    return r;
  endfunction
endpackage

// File: rtl/can_mem_clear_ctrl.sv
// can_mem_clear_ctrl: sweeps zeros through the array after reset or on request
module can_mem_clear_ctrl import can_mem_pkg::*; #(
  parameter int DEPTH = CAN_MEM_DEPTH,
  parameter int ADDR_W = can_mem_clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  output logic              busy,
  output logic              clr_we,
  output logic [ADDR_W-1:0] clr_addr
);
  mem_state_e state, state_nxt;
  logic [ADDR_W-1:0] clr_ptr, ptr_nxt;
  // state and sweep pointer; reset always restarts the sweep from entry 0
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= ST_CLEAR;
      clr_ptr <= '0;
    end else begin
      state <= state_nxt;
      clr_ptr <= ptr_nxt;
    end
  // leave the sweep after the last entry; clr is only honoured when idle
  always_comb begin
    state_nxt = busy ? (clr_ptr == ADDR_W'(DEPTH - 1) ? ST_IDLE : ST_CLEAR)
                     : (clr ? ST_CLEAR : ST_IDLE);
    ptr_nxt = busy ? clr_ptr + 1'b1 : '0;
  end
  assign busy = state == ST_CLEAR;
  assign clr_we = busy;
  assign clr_addr = clr_ptr;
endmodule

// File: rtl/can_msg_ram.sv
// can_msg_ram: dual-port message RAM with auto-clear and write-collision arbitration
module can_msg_ram import can_mem_pkg::*; #(
  parameter int DATA_W = CAN_MEM_DATA_W,
  parameter int DEPTH = CAN_MEM_DEPTH,
  parameter int ADDR_W = can_mem_clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  output logic              busy,
  input  logic              a_en,
  input  logic              a_we,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [DATA_W-1:0] a_din,
  output logic [DATA_W-1:0] a_dout,
  output logic              a_valid,
  input  logic              b_en,
  input  logic              b_we,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [DATA_W-1:0] b_din,
  output logic [DATA_W-1:0] b_dout,
  output logic              b_valid,
  output logic              wr_conflict
);
  logic [DATA_W-1:0] mem [DEPTH];
  logic clr_we, a_ok, b_ok, a_wr, b_wr, a_rd, b_rd;
  logic [ADDR_W-1:0] clr_addr;
  can_mem_clear_ctrl #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) u_clear (
    .clk(clk), .rst(rst), .clr(clr), .busy(busy), .clr_we(clr_we), .clr_addr(clr_addr)
  );
  assign a_ok = 32'(a_addr) < DEPTH;
  assign b_ok = 32'(b_addr) < DEPTH;
  assign a_wr = !busy && a_en && a_we && a_ok;
  assign b_wr = !busy && b_en && b_we && b_ok;
  assign a_rd = !busy && a_en && !a_we;
  assign b_rd = !busy && b_en && !b_we;
  // storage: the sweep owns the array while busy; A is applied last so it wins a collision
  always_ff @(posedge clk)
    if (clr_we) mem[clr_addr] <= '0;
    else begin
      if (b_wr) mem[b_addr] <= b_din;
      if (a_wr) mem[a_addr] <= a_din;
    end
  // registered read data, valid and conflict pulses; reads see pre-write data
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      a_dout <= '0;
      b_dout <= '0;
      a_valid <= 1'b0;
      b_valid <= 1'b0;
      wr_conflict <= 1'b0;
    end else begin
      a_valid <= a_rd;
      b_valid <= b_rd;
      if (a_rd) a_dout <= a_ok ? mem[a_addr] : '0;
      if (b_rd) b_dout <= b_ok ? mem[b_addr] : '0;
      wr_conflict <= a_wr && b_wr && a_addr == b_addr;
    end
endmodule

// File: tb/tb_can_msg_ram.sv
// tb_can_msg_ram: randomized and directed checks against a behavioural memory model
module tb_can_msg_ram;
  logic clk = 0, rst = 1, clr = 0, busy, wr_conflict;
  logic a_en = 0, a_we = 0, b_en = 0, b_we = 0, a_valid, b_valid;
  logic [7:0] a_addr = 0, b_addr = 0, a_din = 0, b_din = 0, a_dout, b_dout;
  logic c_en = 0, c_we = 0, c_valid, c_busy, c_conf, z_valid;
  logic [7:0] c_addr = 0, c_din = 0, c_dout, z_dout;
  logic [7:0] ref_mem [256];
  int checks = 0, errors = 0;

  always #5 clk = ~clk;

  can_msg_ram dut (
    .clk(clk), .rst(rst), .clr(clr), .busy(busy),
    .a_en(a_en), .a_we(a_we), .a_addr(a_addr), .a_din(a_din), .a_dout(a_dout), .a_valid(a_valid),
    .b_en(b_en), .b_we(b_we), .b_addr(b_addr), .b_din(b_din), .b_dout(b_dout), .b_valid(b_valid),
    .wr_conflict(wr_conflict)
  );

  can_msg_ram #(.DEPTH(200)) dut200 (
    .clk(clk), .rst(rst), .clr(1'b0), .busy(c_busy),
    .a_en(c_en), .a_we(c_we), .a_addr(c_addr), .a_din(c_din), .a_dout(c_dout), .a_valid(c_valid),
    .b_en(1'b0), .b_we(1'b0), .b_addr(8'h00), .b_din(8'h00), .b_dout(z_dout), .b_valid(z_valid),
    .wr_conflict(c_conf)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic zero_model();
    for (int i = 0; i < 256; i++) ref_mem[i] = 8'h00;
  endtask

  task automatic test_reset();
    int n0, n1;
    rst = 1;
    repeat (3) tick();
    checks += 6;
    if (busy !== 1'b1) begin errors++; $display("FAIL reset_busy got %0b exp 1", busy); end
    if (a_valid !== 1'b0) begin errors++; $display("FAIL reset_a_valid got %0b exp 0", a_valid); end
    if (a_dout !== 8'h00) begin errors++; $display("FAIL reset_a_dout got %0h exp 0", a_dout); end
    if (b_dout !== 8'h00) begin errors++; $display("FAIL reset_b_dout got %0h exp 0", b_dout); end
    if (wr_conflict !== 1'b0) begin errors++; $display("FAIL reset_conflict got %0b exp 0", wr_conflict); end
    if (c_busy !== 1'b1) begin errors++; $display("FAIL reset_busy200 got %0b exp 1", c_busy); end
    rst = 0;
    n0 = 0;
    n1 = 0;
    for (int k = 0; k < 600; k++) begin
      if (busy) n0++;
      if (c_busy) n1++;
      tick();
    end
    checks += 2;
    if (n0 != 256) begin errors++; $display("FAIL sweep_len got %0d exp 256", n0); end
    if (n1 != 200) begin errors++; $display("FAIL sweep_len200 got %0d exp 200", n1); end
    zero_model();
    for (int k = 0; k < 3; k++) begin
      a_en = 1;
      a_we = 0;
      a_addr = k == 0 ? 8'h00 : k == 1 ? 8'h7F : 8'hFF;
      tick();
      checks += 2;
      if (a_valid !== 1'b1) begin errors++; $display("FAIL reset_rd_valid addr %0h got %0b exp 1", a_addr, a_valid); end
      if (a_dout !== 8'h00) begin errors++; $display("FAIL reset_rd addr %0h got %0h exp 0", a_addr, a_dout); end
    end
    a_en = 0;
  endtask

  task automatic test_fill();
    for (int i = 0; i <= 256; i++) begin
      a_en = i < 256;
      a_we = 1;
      a_addr = 8'(i);
      a_din = 8'(i + 1);
      b_en = i > 0;
      b_we = 0;
      b_addr = 8'(i - 1);
      tick();
      if (i > 0) begin
        checks += 2;
        if (b_valid !== 1'b1) begin errors++; $display("FAIL fill_valid addr %0h got %0b exp 1", b_addr, b_valid); end
        if (b_dout !== ref_mem[i - 1]) begin errors++; $display("FAIL fill_rd addr %0h got %0h exp %0h", b_addr, b_dout, ref_mem[i - 1]); end
      end
      if (i < 256) ref_mem[i] = 8'(i + 1);
    end
    a_en = 1;
    a_we = 0;
    a_addr = 8'hFF;
    b_en = 0;
    tick();
    a_en = 0;
    checks++;
    if (a_dout !== 8'h00) begin errors++; $display("FAIL fill_ff got %0h exp 0", a_dout); end
  endtask

  task automatic test_collision();
    a_en = 1; a_we = 1; a_addr = 8'h55; a_din = 8'hAA;
    b_en = 1; b_we = 1; b_addr = 8'h55; b_din = 8'h33;
    tick();
    ref_mem[8'h55] = 8'hAA;
    a_en = 0; b_en = 0;
    checks++;
    if (wr_conflict !== 1'b1) begin errors++; $display("FAIL conflict_pulse got %0b exp 1", wr_conflict); end
    tick();
    checks += 3;
    if (wr_conflict !== 1'b0) begin errors++; $display("FAIL conflict_clear got %0b exp 0", wr_conflict); end
    if (a_valid !== 1'b0) begin errors++; $display("FAIL idle_valid got %0b exp 0", a_valid); end
    if (a_dout !== 8'h00) begin errors++; $display("FAIL dout_hold got %0h exp 0", a_dout); end
    b_en = 1; b_we = 0; b_addr = 8'h55;
    tick();
    checks++;
    if (b_dout !== 8'hAA) begin errors++; $display("FAIL conflict_winner got %0h exp aa", b_dout); end
    a_en = 1; a_we = 1; a_addr = 8'h40; a_din = 8'h11;
    b_addr = 8'h40;
    tick();
    a_en = 0;
    checks++;
    if (b_dout !== ref_mem[8'h40]) begin errors++; $display("FAIL read_first got %0h exp %0h", b_dout, ref_mem[8'h40]); end
    ref_mem[8'h40] = 8'h11;
    tick();
    b_en = 0;
    checks++;
    if (b_dout !== 8'h11) begin errors++; $display("FAIL after_write got %0h exp 11", b_dout); end
  endtask

  task automatic test_random();
    logic ea, eb;
    logic [7:0] da, db;
    for (int k = 0; k < 400; k++) begin
      a_en = 1'($urandom);
      a_we = 1'($urandom);
      b_en = 1'($urandom);
      b_we = 1'($urandom);
      a_addr = $urandom_range(0, 1) ? 8'($urandom_range(0, 3)) : 8'($urandom);
      b_addr = $urandom_range(0, 1) ? 8'($urandom_range(0, 3)) : 8'($urandom);
      a_din = 8'($urandom);
      b_din = 8'($urandom);
      ea = a_en && !a_we;
      eb = b_en && !b_we;
      da = ref_mem[a_addr];
      db = ref_mem[b_addr];
      tick();
      checks += 3;
      if (a_valid !== ea) begin errors++; $display("FAIL rnd_a_valid cyc %0d got %0b exp %0b", k, a_valid, ea); end
      if (b_valid !== eb) begin errors++; $display("FAIL rnd_b_valid cyc %0d got %0b exp %0b", k, b_valid, eb); end
      if (wr_conflict !== (a_en && a_we && b_en && b_we && a_addr == b_addr)) begin
        errors++; $display("FAIL rnd_conflict cyc %0d got %0b", k, wr_conflict);
      end
      if (ea) begin
        checks++;
        if (a_dout !== da) begin errors++; $display("FAIL rnd_a_dout cyc %0d got %0h exp %0h", k, a_dout, da); end
      end
      if (eb) begin
        checks++;
        if (b_dout !== db) begin errors++; $display("FAIL rnd_b_dout cyc %0d got %0h exp %0h", k, b_dout, db); end
      end
      if (b_en && b_we) ref_mem[b_addr] = b_din;
      if (a_en && a_we) ref_mem[a_addr] = a_din;
    end
    a_en = 0;
    b_en = 0;
    tick();
  endtask

  task automatic test_clr();
    int n;
    a_en = 1; a_we = 1; a_addr = 8'h10; a_din = 8'h5A;
    tick();
    a_en = 0;
    clr = 1;
    tick();
    clr = 0;
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL clr_busy got %0b exp 1", busy); end
    n = 1;
    a_en = 1; a_we = 1; a_addr = 8'h20; a_din = 8'hFF;
    b_en = 1; b_we = 0; b_addr = 8'h10;
    for (int k = 0; k < 600; k++) begin
      tick();
      checks += 2;
      if (a_valid !== 1'b0) begin errors++; $display("FAIL clr_a_valid cyc %0d got %0b exp 0", k, a_valid); end
      if (b_valid !== 1'b0) begin errors++; $display("FAIL clr_b_valid cyc %0d got %0b exp 0", k, b_valid); end
      if (!busy) break;
      n++;
    end
    checks++;
    if (n != 256) begin errors++; $display("FAIL clr_len got %0d exp 256", n); end
    zero_model();
    a_we = 0;
    b_addr = 8'h20;
    a_addr = 8'h10;
    tick();
    a_en = 0;
    b_en = 0;
    checks += 2;
    if (a_dout !== 8'h00 || a_valid !== 1'b1) begin errors++; $display("FAIL clr_rd10 got %0h/%0b exp 0/1", a_dout, a_valid); end
    if (b_dout !== 8'h00 || b_valid !== 1'b1) begin errors++; $display("FAIL clr_rd20 got %0h/%0b exp 0/1", b_dout, b_valid); end
  endtask

  task automatic test_rst_mid_clear();
    int n0, n1;
    a_en = 1; a_we = 1; a_addr = 8'hC8; a_din = 8'h77;
    tick();
    a_en = 0;
    clr = 1;
    tick();
    clr = 0;
    repeat (100) tick();
    rst = 1;
    #1;
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL rst_mid_busy got %0b exp 1", busy); end
    tick();
    rst = 0;
    n0 = 0;
    n1 = 0;
    for (int k = 0; k < 600; k++) begin
      if (busy) n0++;
      if (c_busy) n1++;
      tick();
    end
    checks += 2;
    if (n0 != 256) begin errors++; $display("FAIL rst_mid_len got %0d exp 256", n0); end
    if (n1 != 200) begin errors++; $display("FAIL rst_mid_len200 got %0d exp 200", n1); end
    zero_model();
    for (int i = 0; i < 256; i++) begin
      a_en = 1; a_we = 0; a_addr = 8'(i);
      b_en = 1; b_we = 0; b_addr = 8'(255 - i);
      tick();
      checks += 2;
      if (a_dout !== 8'h00) begin errors++; $display("FAIL rst_mid_a addr %0h got %0h exp 0", a_addr, a_dout); end
      if (b_dout !== 8'h00) begin errors++; $display("FAIL rst_mid_b addr %0h got %0h exp 0", b_addr, b_dout); end
    end
    a_en = 0;
    b_en = 0;
  endtask

  task automatic test_npot();
    c_en = 1; c_we = 1; c_addr = 8'd210; c_din = 8'h77;
    tick();
    checks++;
    if (c_conf !== 1'b0) begin errors++; $display("FAIL npot_conflict got %0b exp 0", c_conf); end
    c_addr = 8'd5; c_din = 8'h66;
    tick();
    c_we = 0;
    c_addr = 8'd210;
    tick();
    checks += 2;
    if (c_valid !== 1'b1) begin errors++; $display("FAIL npot_oor_valid got %0b exp 1", c_valid); end
    if (c_dout !== 8'h00) begin errors++; $display("FAIL npot_oor_rd got %0h exp 0", c_dout); end
    c_addr = 8'd5;
    tick();
    checks++;
    if (c_dout !== 8'h66) begin errors++; $display("FAIL npot_rd5 got %0h exp 66", c_dout); end
    c_addr = 8'd10;
    tick();
    c_en = 0;
    checks++;
    if (c_dout !== 8'h00) begin errors++; $display("FAIL npot_alias got %0h exp 0", c_dout); end
  endtask

  initial begin
    test_reset();
    test_fill();
    test_collision();
    test_random();
    test_clr();
    test_rst_mid_clear();
    test_npot();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
